// File: rtl/serdesphy_prbs_engine.sv
// PRBS generator and self-synchronising PRBS checker for a SERDES PHY.
// The generator emits DATA_W bits per word, MSB first in time. The checker
// seeds its LFSR from received data, then predicts each following bit. It
// tracks lock/loss and keeps a saturating bit-error count.
module serdesphy_prbs_engine #(
    parameter int DATA_W     = 4,
    parameter int CNT_W      = 16,
    parameter int LOCK_WORDS = 8,
    parameter int LOSS_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              gen_en,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              chk_en,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              err_clr,
    output logic              prbs_lock,
    output logic              prbs_err,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int LOCK_W = $clog2(LOCK_WORDS + 1);
    localparam int LOSS_W = $clog2(LOSS_WORDS + 1);
    localparam int SEED_W = 6;
    localparam int PC_W   = 5;
    localparam int SUM_W  = CNT_W + PC_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SEED  = 2'b01,
        ST_CHECK = 2'b10
    } chk_state_t;

    // Feedback bit for the selected polynomial: s[A-1] ^ s[B-1]
    function automatic logic fb_bit(input logic [30:0] s, input logic [1:0] m);
        logic b;
        case (m)
            2'b00:   b = s[6]  ^ s[5];
            2'b01:   b = s[8]  ^ s[4];
            2'b10:   b = s[14] ^ s[13];
            2'b11:   b = s[30] ^ s[27];
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    // Polynomial order, i.e. how many seed bits make the checker LFSR valid
    function automatic logic [SEED_W-1:0] poly_order(input logic [1:0] m);
        logic [SEED_W-1:0] o;
        case (m)
            2'b00:   o = 6'd7;
            2'b01:   o = 6'd9;
            2'b10:   o = 6'd15;
            2'b11:   o = 6'd31;
            default: o = 6'd31;
        endcase
        return o;
    endfunction

    // Next DATA_W feedback bits, first bit in the MSB
    function automatic logic [DATA_W-1:0] lfsr_word(input logic [30:0] s_in, input logic [1:0] m);
        logic [30:0]       s;
        logic [DATA_W-1:0] w;
        logic              b;
        s = s_in;
        w = '0;
        for (int i = 0; i < DATA_W; i++) begin
            b                 = fb_bit(s, m);
            w[DATA_W - 1 - i] = b;
            s                 = {s[29:0], b};
        end
        return w;
    endfunction

    // LFSR state after DATA_W feedback shifts
    function automatic logic [30:0] lfsr_adv(input logic [30:0] s_in, input logic [1:0] m);
        logic [30:0] s;
        s = s_in;
        for (int i = 0; i < DATA_W; i++) begin
            s = {s[29:0], fb_bit(s, m)};
        end
        return s;
    endfunction

    // Shift a received word straight into the LFSR, MSB first
    function automatic logic [30:0] seed_shift(input logic [30:0] s, input logic [DATA_W-1:0] w);
        logic [30+DATA_W:0] t;
        t = {s, w};
        return t[30:0];
    endfunction

    // Number of set bits in a word
    function automatic logic [PC_W-1:0] popcount(input logic [DATA_W-1:0] w);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_W; i++) begin
            c = c + {{(PC_W-1){1'b0}}, w[i]};
        end
        return c;
    endfunction

    logic [1:0]        mode_q;
    logic [30:0]       gen_lfsr_q, gen_lfsr_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    chk_state_t        state_q, state_d;
    logic [30:0]       chk_lfsr_q, chk_lfsr_d;
    logic [SEED_W-1:0] seed_bits_q, seed_bits_d;
    logic [LOCK_W-1:0] good_run_q, good_run_d;
    logic [LOSS_W-1:0] bad_run_q, bad_run_d;
    logic              lock_q, lock_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_next_s;

    logic              mode_chg_s;
    logic [30:0]       gen_adv_s;
    logic [DATA_W-1:0] mism_s;
    logic [PC_W-1:0]   pc_s;
    logic [SUM_W-1:0]  sum_s;
    logic [CNT_W-1:0]  sat_s;

    assign mode_chg_s = (mode != mode_q);
    assign gen_adv_s  = lfsr_adv(gen_lfsr_q, mode);
    assign mism_s     = rx_data ^ lfsr_word(chk_lfsr_q, mode);
    assign pc_s       = popcount(mism_s);
    assign sum_s      = SUM_W'(cnt_q) + SUM_W'(pc_s);
    assign sat_s      = (sum_s[SUM_W-1:CNT_W] != '0) ? {CNT_W{1'b1}} : sum_s[CNT_W-1:0];

    // Generator: the LFSR holds the state at the start of the word on tx_data
    always_comb begin
        gen_lfsr_d = gen_lfsr_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = gen_en;
        if (mode_chg_s) begin
            gen_lfsr_d = {31{1'b1}};
            tx_data_d  = lfsr_word({31{1'b1}}, mode);
        end else if (tx_valid_q && tx_ready) begin
            gen_lfsr_d = gen_adv_s;
            tx_data_d  = lfsr_word(gen_adv_s, mode);
        end else if (gen_en && !tx_valid_q) begin
            tx_data_d  = lfsr_word(gen_lfsr_q, mode);
        end else begin
            tx_data_d  = tx_data_q;
        end
    end

    // Checker FSM: seed from the line, then predict and count mismatches
    always_comb begin
        state_d     = state_q;
        chk_lfsr_d  = chk_lfsr_q;
        seed_bits_d = seed_bits_q;
        good_run_d  = good_run_q;
        bad_run_d   = bad_run_q;
        lock_d      = lock_q;
        err_d       = 1'b0;
        cnt_next_s  = cnt_q;
        if (!chk_en) begin
            state_d     = ST_IDLE;
            lock_d      = 1'b0;
            seed_bits_d = '0;
            good_run_d  = '0;
            bad_run_d   = '0;
        end else if (mode_chg_s) begin
            state_d     = ST_SEED;
            lock_d      = 1'b0;
            seed_bits_d = '0;
            good_run_d  = '0;
            bad_run_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d     = ST_SEED;
                    seed_bits_d = '0;
                end
                ST_SEED: begin
                    if (rx_valid) begin
                        chk_lfsr_d = seed_shift(chk_lfsr_q, rx_data);
                        if ((seed_bits_q + SEED_W'(DATA_W)) >= poly_order(mode)) begin
                            state_d     = ST_CHECK;
                            seed_bits_d = '0;
                        end else begin
                            seed_bits_d = seed_bits_q + SEED_W'(DATA_W);
                        end
                    end else begin
                        chk_lfsr_d = chk_lfsr_q;
                    end
                end
                ST_CHECK: begin
                    if (rx_valid) begin
                        // predicted bits are shifted in so one bad bit cannot corrupt prediction
                        chk_lfsr_d = lfsr_adv(chk_lfsr_q, mode);
                        if (pc_s != '0) begin
                            err_d      = 1'b1;
                            cnt_next_s = sat_s;
                            good_run_d = '0;
                            if ((32'(bad_run_q) + 32'd1) >= 32'(LOSS_WORDS)) begin
                                lock_d      = 1'b0;
                                state_d     = ST_SEED;
                                seed_bits_d = '0;
                                bad_run_d   = '0;
                            end else begin
                                bad_run_d = bad_run_q + LOSS_W'(1);
                            end
                        end else begin
                            bad_run_d = '0;
                            if ((32'(good_run_q) + 32'd1) >= 32'(LOCK_WORDS)) begin
                                lock_d     = 1'b1;
                                good_run_d = LOCK_W'(LOCK_WORDS);
                            end else begin
                                good_run_d = good_run_q + LOCK_W'(1);
                            end
                        end
                    end else begin
                        chk_lfsr_d = chk_lfsr_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    lock_d  = 1'b0;
                end
            endcase
        end
        // a clear beats any errors counted in the same cycle
        cnt_d = err_clr ? {CNT_W{1'b0}} : cnt_next_s;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= mode;
            gen_lfsr_q  <= {31{1'b1}};
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            state_q     <= ST_IDLE;
            chk_lfsr_q  <= '0;
            seed_bits_q <= '0;
            good_run_q  <= '0;
            bad_run_q   <= '0;
            lock_q      <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            mode_q      <= mode;
            gen_lfsr_q  <= gen_lfsr_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            state_q     <= state_d;
            chk_lfsr_q  <= chk_lfsr_d;
            seed_bits_q <= seed_bits_d;
            good_run_q  <= good_run_d;
            bad_run_q   <= bad_run_d;
            lock_q      <= lock_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign prbs_lock = lock_q;
    assign prbs_err  = err_q;
    assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_serdesphy_prbs_engine.sv
// Directed bench for serdesphy_prbs_engine: generator vector table, loopback
// lock/error sequences, saturation on a narrow-counter instance, mode sweep.
module tb_serdesphy_prbs_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        gen_en, tx_ready, chk_en, err_clr;
    logic [3:0]  inj;
    logic        rand_rdy;

    logic [3:0]  tx_data,  tx_data4;
    logic        tx_valid, tx_valid4;
    logic        lock,  lock4;
    logic        perr,  perr4;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
    logic [3:0]  rx_data,  rx_data4;
    logic        rx_valid, rx_valid4;

    int checks   = 0;
    int failures = 0;

    assign rx_data   = tx_data  ^ inj;
    assign rx_valid  = tx_valid  & tx_ready;
    assign rx_data4  = tx_data4 ^ inj;
    assign rx_valid4 = tx_valid4 & tx_ready;

    always #5 clk = ~clk;

    serdesphy_prbs_engine #(.DATA_W(4), .CNT_W(16), .LOCK_WORDS(8), .LOSS_WORDS(4)) dut (
        .clk(clk), .rst(rst), .mode(mode), .gen_en(gen_en), .tx_ready(tx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .chk_en(chk_en), .rx_data(rx_data),
        .rx_valid(rx_valid), .err_clr(err_clr), .prbs_lock(lock), .prbs_err(perr),
        .err_cnt(cnt));

    serdesphy_prbs_engine #(.DATA_W(4), .CNT_W(4), .LOCK_WORDS(8), .LOSS_WORDS(4)) dut4 (
        .clk(clk), .rst(rst), .mode(mode), .gen_en(gen_en), .tx_ready(tx_ready),
        .tx_data(tx_data4), .tx_valid(tx_valid4), .chk_en(chk_en), .rx_data(rx_data4),
        .rx_valid(rx_valid4), .err_clr(err_clr), .prbs_lock(lock4), .prbs_err(perr4),
        .err_cnt(cnt4));

    typedef struct {
        logic       gen_en;
        logic       rdy;
        logic       exp_valid;
        logic [3:0] exp_data;
    } gvec_t;

    gvec_t gv[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        if (rand_rdy) tx_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_lock(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (lock) break;
            step();
        end
        check("lock_wait", 32'(lock), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1; gen_en = 1'b0; tx_ready = 1'b0; chk_en = 1'b0;
        err_clr = 1'b0; inj = 4'd0; mode = 2'b00; rand_rdy = 1'b0;
        steps(2);
        rst = 1'b0;
    endtask

    initial begin
        // PRBS7 from all-ones: words 0000 0010 0000 1100 0010 1000 1111
        gv[0]  = '{1'b1, 1'b1, 1'b1, 4'b0000};
        gv[1]  = '{1'b1, 1'b1, 1'b1, 4'b0010};
        gv[2]  = '{1'b1, 1'b0, 1'b1, 4'b0010};
        gv[3]  = '{1'b1, 1'b0, 1'b1, 4'b0010};
        gv[4]  = '{1'b1, 1'b1, 1'b1, 4'b0000};
        gv[5]  = '{1'b0, 1'b1, 1'b0, 4'b1100};
        gv[6]  = '{1'b0, 1'b1, 1'b0, 4'b1100};
        gv[7]  = '{1'b1, 1'b0, 1'b1, 4'b1100};
        gv[8]  = '{1'b1, 1'b1, 1'b1, 4'b0010};
        gv[9]  = '{1'b1, 1'b1, 1'b1, 4'b1000};
        gv[10] = '{1'b1, 1'b1, 1'b1, 4'b1111};

        do_reset();
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_data",  32'(tx_data),  32'd0);
        check("rst_lock",  32'(lock),     32'd0);
        check("rst_err",   32'(perr),     32'd0);
        check("rst_cnt",   32'(cnt),      32'd0);

        // generator table
        for (int i = 0; i < 11; i++) begin
            gen_en = gv[i].gen_en;
            tx_ready = gv[i].rdy;
            step();
            check($sformatf("gen_valid[%0d]", i), 32'(tx_valid), 32'(gv[i].exp_valid));
            check($sformatf("gen_data[%0d]", i),  32'(tx_data),  32'(gv[i].exp_data));
        end

        // loopback lock: 1 idle->seed edge, 2 seed words, 8 clean words
        do_reset();
        gen_en = 1'b1; chk_en = 1'b1; tx_ready = 1'b1;
        steps(10);
        check("lock_early", 32'(lock), 32'd0);
        step();
        check("lock_rise", 32'(lock), 32'd1);
        check("lock_cnt0", 32'(cnt), 32'd0);

        // single-bit error while locked
        inj = 4'b0100; step(); inj = 4'd0;
        check("e1_err",  32'(perr), 32'd1);
        check("e1_cnt",  32'(cnt),  32'd1);
        check("e1_lock", 32'(lock), 32'd1);
        step();
        check("e1_err_off", 32'(perr), 32'd0);
        check("e1_cnt_hold", 32'(cnt), 32'd1);

        // clear, then four full-error words
        err_clr = 1'b1; step(); err_clr = 1'b0;
        check("clr_cnt", 32'(cnt), 32'd0);
        check("clr_cnt4", 32'(cnt4), 32'd0);
        inj = 4'b1111;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("burst_cnt[%0d]", k),  32'(cnt),  32'(4 * k));
            check($sformatf("burst_cnt4[%0d]", k), 32'(cnt4), (4 * k > 15) ? 32'd15 : 32'(4 * k));
            check($sformatf("burst_err[%0d]", k),  32'(perr), 32'd1);
            check($sformatf("burst_lock[%0d]", k), 32'(lock), (k < 4) ? 32'd1 : 32'd0);
        end
        inj = 4'd0;
        steps(9);
        check("relock_early", 32'(lock), 32'd0);
        step();
        check("relock", 32'(lock), 32'd1);
        check("relock_cnt", 32'(cnt), 32'd16);

        // saturation sticks, then clear coincident with an errored word
        inj = 4'b1111;
        steps(3);
        check("sat_cnt4", 32'(cnt4), 32'd15);
        check("sat_cnt",  32'(cnt),  32'd28);
        check("sat_lock", 32'(lock), 32'd1);
        err_clr = 1'b1; step();
        err_clr = 1'b0; inj = 4'd0;
        check("clrwin_cnt",  32'(cnt),  32'd0);
        check("clrwin_cnt4", 32'(cnt4), 32'd0);
        check("clrwin_err",  32'(perr), 32'd1);
        check("clrwin_lock", 32'(lock), 32'd0);
        step();
        check("clrwin_err_off", 32'(perr), 32'd0);
        wait_lock(40);

        // chk_en drop clears lock but keeps the count
        inj = 4'b0001; step(); inj = 4'd0;
        chk_en = 1'b0; step();
        check("chkoff_lock", 32'(lock), 32'd0);
        check("chkoff_cnt",  32'(cnt),  32'd1);
        chk_en = 1'b1;
        wait_lock(40);

        // mode sweep with random backpressure; each change drops then regains lock
        err_clr = 1'b1; step(); err_clr = 1'b0;
        rand_rdy = 1'b1;
        for (int m = 1; m <= 4; m++) begin
            mode = 2'(m % 4);
            step();
            check($sformatf("mode%0d_drop", m % 4), 32'(lock), 32'd0);
            wait_lock(500);
            steps(20);
            check($sformatf("mode%0d_hold", m % 4), 32'(lock), 32'd1);
            check($sformatf("mode%0d_cnt", m % 4),  32'(cnt),  32'd0);
        end
        rand_rdy = 1'b0;

        // reset mid-operation overrides everything
        inj = 4'b1111; err_clr = 1'b0; tx_ready = 1'b1;
        rst = 1'b1; step(); rst = 1'b0; inj = 4'd0;
        check("mrst_valid", 32'(tx_valid), 32'd0);
        check("mrst_data",  32'(tx_data),  32'd0);
        check("mrst_lock",  32'(lock),     32'd0);
        check("mrst_err",   32'(perr),     32'd0);
        check("mrst_cnt4",  32'(cnt4),     32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
